// File: rtl/mxpl_pkg.sv
// Shared constants for the pooling engine: mode encodings and the default sample width.
package mxpl_pkg;

  localparam logic [1:0] MODE_MAX = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_AVG = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam int DEFAULT_DATAW = 20;

  // The reserved encoding behaves as max, so it is folded away once at latch time.
  function automatic logic [1:0] effMode(input logic [1:0] m);
    return (m == MODE_RSV) ? MODE_MAX : m;
  endfunction

endpackage

// File: rtl/mxpl_pool_alu.sv
// Combinational update step for one channel accumulator: load, max, min or running sum.
module mxpl_pool_alu
  import mxpl_pkg::*;
#(
  parameter int DATAW = DEFAULT_DATAW,
  parameter int ACCW  = DATAW + 2
) (
  input  logic [1:0]              i_mode,
  input  logic                    i_first,
  input  logic signed [ACCW-1:0]  i_stored,
  input  logic signed [DATAW-1:0] i_sample,
  output logic signed [ACCW-1:0]  o_next
);

  logic signed [ACCW-1:0] w_ext;

  assign w_ext = {{(ACCW-DATAW){i_sample[DATAW-1]}}, i_sample};

  // Samples live sign-extended in the wide accumulator so one signed compare serves every mode.
  always_comb begin
    o_next = i_stored;
    if (i_first) begin
      o_next = w_ext;
    end else begin
      case (i_mode)
        MODE_MIN: if (w_ext < i_stored) o_next = w_ext;
        MODE_AVG: o_next = i_stored + w_ext;
        default:  if (w_ext > i_stored) o_next = w_ext;
      endcase
    end
  end

endmodule

// File: rtl/mxpl_pool_engine.sv
// Windowed max/min/average pooling over CH round-robin interleaved channels, one result per channel per window.
module mxpl_pool_engine
  import mxpl_pkg::*;
#(
  parameter int DATAW = DEFAULT_DATAW,
  parameter int WIN   = 4,
  parameter int CH    = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic signed [DATAW-1:0]               in_data,
  output logic                                  in_ready,
  input  logic [1:0]                            mode,
  input  logic                                  abort,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [DATAW-1:0]               out_data,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch
);

  localparam int LOGW = $clog2(WIN);
  localparam int ACCW = DATAW + LOGW;
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;

  logic [CHW-1:0]         r_ch;
  logic [LOGW-1:0]        r_rnd;
  logic [1:0]             r_mode;
  logic signed [ACCW-1:0] r_acc [CH];

  logic                    w_accept;
  logic                    w_first;
  logic                    w_last;
  logic                    w_chLast;
  logic signed [ACCW-1:0]  w_stored;
  logic signed [ACCW-1:0]  w_next;
  logic signed [DATAW-1:0] w_avgRes;
  logic signed [DATAW-1:0] w_result;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !abort;
  assign w_first  = (r_rnd == '0);
  assign w_last   = (r_rnd == LOGW'(WIN - 1));
  assign w_chLast = (r_ch == CHW'(CH - 1));
  assign w_stored = r_acc[r_ch];

  mxpl_pool_alu #(
    .DATAW(DATAW),
    .ACCW (ACCW)
  ) u_alu (
    .i_mode  (r_mode),
    .i_first (w_first),
    .i_stored(w_stored),
    .i_sample(in_data),
    .o_next  (w_next)
  );

  // The sum of WIN samples shifted back by log2(WIN) always fits DATAW, so truncation is exact.
  assign w_avgRes = DATAW'(w_next >>> LOGW);
  assign w_result = (r_mode == MODE_AVG) ? w_avgRes : w_next[DATAW-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ch      <= '0;
      r_rnd     <= '0;
      r_mode    <= MODE_MAX;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      for (int i = 0; i < CH; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      if (abort) begin
        r_ch  <= '0;
        r_rnd <= '0;
      end else if (w_accept) begin
        r_acc[r_ch] <= w_next;
        if (w_chLast) begin
          r_ch  <= '0;
          r_rnd <= w_last ? '0 : r_rnd + LOGW'(1);
        end else begin
          r_ch <= r_ch + CHW'(1);
        end
        // Round 0 just loads, so the freshly latched mode is only needed from round 1 onward.
        if (w_first && (r_ch == '0)) begin
          r_mode <= effMode(mode);
        end
      end

      if (w_accept && w_last) begin
        out_valid <= 1'b1;
        out_data  <= w_result;
        out_ch    <= r_ch;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
